// File: rtl/sample_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_fetch_pkg : shared widths and index helpers for the sample fetcher
// Revision: 1.0
// ---------------------------------------------------------------------------
package sample_fetch_pkg;

  localparam int OVF_CNT_W = 16;

  // Minimum 1 so that degenerate counters still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int tap_lsb(input int ch, input int slot,
                                 input int s_depth, input int s_width);
    return (ch * s_depth + slot) * s_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Fifo : power-of-two circular buffer; occupancy is tracked by the caller
// Revision: 1.0
// ---------------------------------------------------------------------------
module Fifo
  import sample_fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/sample_fetch_shift_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Shift_Register : tap-delay line, slot 0 newest, clearable
// Revision: 1.0
// ---------------------------------------------------------------------------
module Shift_Register #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] taps
);

  logic [DEPTH*WIDTH-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clear) begin
      taps_d = '0;
    end else if (shift) begin
      taps_d[0 +: WIDTH] = din;
      for (int k = 1; k < DEPTH; k++) begin
        taps_d[k*WIDTH +: WIDTH] = taps_q[(k-1)*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) taps_q <= '0;
    else       taps_q <= taps_d;
  end

  assign taps = taps_q;

endmodule
`default_nettype wire

// File: rtl/multi_chan_sample_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_chan_sample_fetch : N-channel sample FIFO feeding per-channel tap lines
// Revision: 1.0
// ---------------------------------------------------------------------------
module multi_chan_sample_fetch
  import sample_fetch_pkg::*;
#(
  parameter int S_WIDTH     = 24,
  parameter int S_DEPTH     = 29,
  parameter int N_CH        = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int AFULL_LEVEL = FIFO_DEPTH - 1,
  parameter int DECIM       = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [N_CH*S_WIDTH-1:0]           in_data,
  output logic                              in_stop,
  input  logic                              can_shift,
  input  logic                              ovf_clr,
  output logic [N_CH*S_DEPTH*S_WIDTH-1:0]   taps,
  output logic                              shift_pulse,
  output logic                              window_valid,
  output logic                              frame_ready,
  output logic                              empty,
  output logic [clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                              overflow,
  output logic [OVF_CNT_W-1:0]              ovf_count
);

  localparam int WORD_W = N_CH * S_WIDTH;
  localparam int LVL_W  = clog2(FIFO_DEPTH + 1);
  localparam int FILL_W = clog2(S_DEPTH + 1);
  localparam int PH_W   = clog2(DECIM);

  logic [LVL_W-1:0]     level_q, level_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 empty_q, empty_d;
  logic                 shift_pulse_q, shift_pulse_d;
  logic                 frame_ready_q, frame_ready_d;
  logic                 overflow_q, overflow_d;
  logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              shift;
  logic              drop;
  logic [WORD_W-1:0] fifo_rd_data;

  // Full comes from the pre-cycle level, so a same-cycle pop never frees a slot.
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = in_valid & ~fifo_full & ~flush;
  assign shift      = can_shift & ~fifo_empty & ~flush;
  assign drop       = in_valid & fifo_full & ~flush;

  always_comb begin
    level_d       = level_q;
    fill_d        = fill_q;
    phase_d       = phase_q;
    empty_d       = fifo_empty;
    shift_pulse_d = shift;
    frame_ready_d = 1'b0;
    overflow_d    = overflow_q;
    ovf_count_d   = ovf_count_q;

    if (flush) begin
      level_d = '0;
      fill_d  = '0;
      phase_d = '0;
    end else begin
      level_d = level_q + LVL_W'(push) - LVL_W'(shift);
      if (shift && (fill_q != FILL_W'(S_DEPTH))) fill_d = fill_q + FILL_W'(1);
      // Decimation only counts shifts that land on a fully primed window.
      if (shift && (fill_d == FILL_W'(S_DEPTH))) begin
        frame_ready_d = (phase_q == '0);
        phase_d       = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)           ovf_count_d = OVF_CNT_W'(1);
      else if (~&ovf_count_q) ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
    end else if (ovf_clr) begin
      overflow_d  = 1'b0;
      ovf_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q       <= '0;
      fill_q        <= '0;
      phase_q       <= '0;
      empty_q       <= 1'b1;
      shift_pulse_q <= 1'b0;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      ovf_count_q   <= '0;
    end else begin
      level_q       <= level_d;
      fill_q        <= fill_d;
      phase_q       <= phase_d;
      empty_q       <= empty_d;
      shift_pulse_q <= shift_pulse_d;
      frame_ready_q <= frame_ready_d;
      overflow_q    <= overflow_d;
      ovf_count_q   <= ovf_count_d;
    end
  end

  Fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (push),
    .pop     (shift),
    .wr_data (in_data),
    .rd_data (fifo_rd_data)
  );

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    Shift_Register #(
      .WIDTH (S_WIDTH),
      .DEPTH (S_DEPTH)
    ) u_taps (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .shift (shift),
      .din   (fifo_rd_data[c*S_WIDTH +: S_WIDTH]),
      .taps  (taps[tap_lsb(c, 0, S_DEPTH, S_WIDTH) +: S_DEPTH*S_WIDTH])
    );
  end

  assign level        = level_q;
  assign empty        = empty_q;
  assign in_stop      = (level_q >= LVL_W'(AFULL_LEVEL));
  assign window_valid = (fill_q == FILL_W'(S_DEPTH));
  assign shift_pulse  = shift_pulse_q;
  assign frame_ready  = frame_ready_q;
  assign overflow     = overflow_q;
  assign ovf_count    = ovf_count_q;

endmodule
`default_nettype wire
